// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the 7-segment scan driver
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low cathode patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_o = SEG_HEX_0;
            4'h1: seg_o = SEG_HEX_1;
            4'h2: seg_o = SEG_HEX_2;
            4'h3: seg_o = SEG_HEX_3;
            4'h4: seg_o = SEG_HEX_4;
            4'h5: seg_o = SEG_HEX_5;
            4'h6: seg_o = SEG_HEX_6;
            4'h7: seg_o = SEG_HEX_7;
            4'h8: seg_o = SEG_HEX_8;
            4'h9: seg_o = SEG_HEX_9;
            4'hA: seg_o = SEG_HEX_A;
            4'hB: seg_o = SEG_HEX_B;
            4'hC: seg_o = SEG_HEX_C;
            4'hD: seg_o = SEG_HEX_D;
            4'hE: seg_o = SEG_HEX_E;
            default: seg_o = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit multiplexed 7-segment driver with per-frame snapshot
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg_num,
    input  logic        en,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int             PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  PS_LAST  = PW'(CLK_DIV - 1);
    localparam logic [2:0]     IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [PW-1:0] prescaler_q;
    logic [2:0]    idx_q;
    logic [31:0]   shadow_q;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_tick_q;

    logic          tick;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic          upper_zero;
    logic          blank;

    assign tick   = (prescaler_q == PS_LAST);
    assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    // A digit is a leading zero only if it and every more-significant nibble are zero
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (3'(k) >= idx_q && shadow_q[4*k +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign blank = blank_lz && (idx_q != 3'd0) && upper_zero;

    always_comb begin
        an_d  = ~(8'b1 << idx_q);
        seg_d = dec_seg;
        if (!en || blank) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q  <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= 32'h0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= tick ? '0 : prescaler_q + 1'b1;
            frame_tick_q <= tick && (idx_q == IDX_LAST);
            an_q         <= an_d;
            seg_q        <= seg_d;
            if (tick) begin
                idx_q <= idx_q + 3'd1;
                if (idx_q == IDX_LAST) begin
                    shadow_q <= seg_num;
                end
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - table-driven self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seg_num;
    logic        en;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0]     num;
        logic            en;
        logic            blz;
        logic [7:0][7:0] an;
        logic [7:0][6:0] seg;
    } vec_t;

    vec_t tbl [8];
    vec_t v_zero, v_abcd;

    seg7_scan_driver #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_num    (seg_num),
        .en         (en),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] num, input logic e, input logic b,
                                input logic [7:0] lit, input logic [55:0] segs);
        vec_t r;
        r.num = num;
        r.en  = e;
        r.blz = b;
        for (int d = 0; d < 8; d++) begin
            r.an[d]  = lit[d] ? ~(8'b1 << d) : 8'hFF;
            r.seg[d] = lit[d] ? segs[7*d +: 7] : 7'h7F;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts on a frame_tick negedge (or reset release) and walks the 32 cycles of one frame
    task automatic check_frame(input vec_t v, input int chg_at, input logic [31:0] chg_num,
                               input int off_lo, input int off_hi);
        int d;
        logic off;
        for (int i = 0; i < 32; i++) begin
            if (i == chg_at) seg_num = chg_num;
            en       = (i >= off_lo && i < off_hi) ? 1'b0 : v.en;
            blank_lz = v.blz;
            off      = !en;
            @(negedge clk);
            d = i / 4;
            chk($sformatf("an[d%0d]", d), 32'(an), off ? 32'hFF : 32'(v.an[d]));
            chk($sformatf("seg[d%0d]", d), 32'(seg), off ? 32'h7F : 32'(v.seg[d]));
            chk("frame_tick", 32'(frame_tick), (i == 31) ? 32'd1 : 32'd0);
            chk("dp", 32'(dp), 32'd1);
        end
    endtask

    initial begin
        v_zero = mk(32'h0, 1'b1, 1'b0, 8'hFF, {8{7'h40}});
        v_abcd = mk(32'h1234_ABCD, 1'b1, 1'b0, 8'hFF,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
        tbl[0] = mk(32'hFFFF_FFFF, 1'b1, 1'b0, 8'hFF, {8{7'h0E}});
        tbl[1] = mk(32'h0000_0050, 1'b1, 1'b1, 8'h03, {{6{7'h7F}}, 7'h12, 7'h40});
        tbl[2] = mk(32'h0000_0000, 1'b1, 1'b1, 8'h01, {{7{7'h7F}}, 7'h40});
        tbl[3] = mk(32'h8000_0001, 1'b1, 1'b1, 8'hFF, {7'h00, {6{7'h40}}, 7'h79});
        tbl[4] = mk(32'h0000_0000, 1'b1, 1'b0, 8'hFF, {8{7'h40}});
        tbl[5] = mk(32'h0765_4321, 1'b1, 1'b1, 8'h7F,
                    {7'h7F, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
        tbl[6] = mk(32'h89AB_CDEF, 1'b0, 1'b0, 8'h00, {8{7'h7F}});
        tbl[7] = mk(32'h89AB_CDEF, 1'b1, 1'b0, 8'hFF,
                    {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});

        rst      = 1'b1;
        seg_num  = 32'h1234_ABCD;
        en       = 1'b1;
        blank_lz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_dp", 32'(dp), 32'd1);
        rst = 1'b0;

        // First frame shows the zeroed shadow; then the snapshot, with a mid-frame change ignored
        check_frame(v_zero, -1, 32'h0, -1, -1);
        check_frame(v_abcd, 13, tbl[0].num, -1, -1);

        for (int k = 0; k < 8; k++) begin
            check_frame(tbl[k], 13, (k < 7) ? tbl[k+1].num : tbl[k].num, -1, -1);
        end

        // Display off for 10 cycles mid-frame; scan and frame cadence carry on
        check_frame(tbl[7], -1, 32'h0, 6, 16);
        check_frame(tbl[7], -1, 32'h0, -1, -1);

        // One-cycle reset mid-frame
        seg_num = 32'h1234_ABCD;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_an", 32'(an), 32'hFF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_frame_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;
        check_frame(v_zero, -1, 32'h0, -1, -1);
        check_frame(v_abcd, -1, 32'h0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumer end of the 32-bit `seg_num` display word produced by the display-mode selector.
- Drives an 8-digit, common-anode, time-multiplexed 7-segment display as 8 hex nibbles.
- Snapshots `seg_num` once per scan frame so the digits never tear, and optionally blanks leading zeros.
- Sits between the mode selector and the board's anode/cathode pins.

Parameters:
- CLK_DIV, 100000: clock cycles each digit stays lit; minimum 2. Simulation uses 4.
- NUM_DIGITS, 8: digits scanned. Fixed at 8, matching the 32-bit word.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- seg_num  in  32  value to display; nibble i goes to digit i, digit 0 is rightmost.
- en  in  1  1 = display on; 0 = all anodes off while the scan keeps running.
- blank_lz  in  1  1 = blank leading zero digits.
- an  out  8  anode enables, active-low, one-hot-low when lit.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held 1 (off).
- frame_tick  out  1  one-cycle pulse when a new frame starts and `seg_num` is sampled.

Behaviour:
- Reset values (synchronous, all registers):
  - prescaler=0, idx=0, shadow=0.
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - `tick` is asserted when prescaler==CLK_DIV-1.
- Digit index idx[2:0]:
  - Advances on `tick`, 7 wraps to 0.
  - When `tick` occurs with idx==7: shadow<=seg_num and frame_tick<=1 for exactly one cycle.
  - `seg_num` is ignored at all other times; mid-frame changes appear only in the next frame.
- Output pipeline:
  - an/seg are registered from (idx, shadow, en, blank_lz), giving a 1-cycle latency after an idx change.
  - Lit digit: an = ~(8'b1<<idx); seg = decode(shadow[4*idx+3 -: 4]).
- Decode table (hex -> seg):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Leading-zero blanking:
  - Applies when blank_lz=1, idx>0, and nibbles idx..7 of shadow are all 0.
  - Blanked digit: an=8'hFF, seg=7'h7F.
  - Digit 0 is never blanked, so value 0 shows as a single "0".
- Disable: with en=0, an=8'hFF and seg=7'h7F (registered, 1 cycle); prescaler, idx and shadow latching continue.
- Pin `dp`: constant 1 after reset.
- Reset mid-frame: all state returns to reset values on the next edge. The first frame after reset displays shadow=0; the new value is sampled at the end of that frame.
- Frame period: 8*CLK_DIV cycles. frame_tick spacing is exactly 8*CLK_DIV cycles.

Decomposition:
- Shared package `seg7_pkg`:
  - Constants SEG_OFF=7'h7F, AN_OFF=8'hFF.
  - The 16 hex segment codes as named constants.
  - NUM_DIGITS.
- One combinational sub-module `hex_to_seg7`: 4-bit in, 7-bit active-low out, using the table above.
- Top level holds the prescaler, idx, shadow, blank logic and output registers.

Test Plan (CLK_DIV=4):
- Reset, seg_num=32'h1234_ABCD, en=1, blank_lz=0:
  - First frame shows all digits "0" (seg=40).
  - After the first frame_tick plus 1 cycle, digit 0 shows an=FE, seg=21 ("d").
  - Digit 7 shows an=7F, seg=79 ("1").
  - Each digit is held 4 cycles.
- Change seg_num to 32'hFFFF_FFFF mid-frame:
  - The current frame is unchanged.
  - The next frame starts after frame_tick and shows seg=0E on all digits.
- seg_num=32'h0000_0050, blank_lz=1:
  - Digits 2..7 are blanked (an=FF).
  - Digit 1 shows seg=12; digit 0 shows seg=40.
  - With seg_num=0 only digit 0 lights, showing "0".
- Toggle en=0 for 10 cycles:
  - an=FF, seg=7F starting 1 cycle later.
  - The frame_tick cadence (every 32 cycles) is unaffected.
  - The display resumes at the correct idx.
- Assert rst for 1 cycle mid-frame:
  - Next cycle an=FF, seg=7F, idx=0, frame_tick=0.
  - The next frame_tick arrives exactly 32 cycles after rst deasserts.
- Sweep nibble values 0..F on digit 0:
  - seg matches the decode table for all 16 values.
  - dp stays 1 throughout.
